// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the M-extension unit and the iterative MDU state set.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Partial remainder stays below the divisor, so the sign of diff decides the quotient bit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[XLEN];
    rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with a final sign-fix cycle.
module mdu_iter
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            ready,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   legal, in_div, sign_a, sign_b, a_neg, b_neg, in_div0, in_ovf;
  logic [2:0]             in_f3;
  logic [XLEN-1:0]        mag_a, mag_b;
  logic                   unused_instr;

  assign rs1_s        = rs1;
  assign rs2_s        = rs2;
  assign unused_instr = ^{Instruction[24:15], Instruction[11:7]};

  always_comb begin
    in_f3   = Instruction[14:12];
    legal   = (Instruction[6:0] == OPCODE_OP) && (Instruction[31:25] == FUNCT7_MULDIV);
    in_div  = in_f3[2];
    // Signed-operand selection: MULHU and the unsigned divides use raw magnitudes.
    sign_a  = in_div ? ~in_f3[0] : (in_f3 != F3_MULHU);
    sign_b  = in_div ? ~in_f3[0] : ~in_f3[1];
    a_neg   = sign_a && (rs1_s < 0);
    b_neg   = sign_b && (rs2_s < 0);
    mag_a   = neg_x(rs1, a_neg);
    mag_b   = neg_x(rs2, b_neg);
    in_div0 = (rs2 == '0);
    in_ovf  = ~in_f3[0] && (rs1 == MOST_NEG) && (rs2 == '1);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] prod;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (hi_q),
    .bit_i     (lo_q[XLEN-1]),
    .divisor_i (opa_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    prod    = neg_2x({hi_q, lo_q}, neg_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    div0_d    = div0_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!legal) begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            illegal_d = 1'b0;
            f3_d      = in_f3;
            cnt_d     = '0;
            hi_d      = '0;
            if (!in_div) begin
              lo_d    = mag_b;
              opa_d   = mag_a;
              neg_d   = a_neg ^ b_neg;
              state_d = S_MUL;
            end else if (FAST_SPECIAL && (in_div0 || in_ovf)) begin
              if (in_div0) result_d = in_f3[1] ? rs1 : '1;
              else         result_d = in_f3[1] ? '0 : rs1;
              state_d = S_DONE;
            end else begin
              lo_d    = mag_a;
              opa_d   = mag_b;
              neg_d   = in_f3[1] ? a_neg : (a_neg ^ b_neg);
              div0_d  = in_div0;
              state_d = S_DIV;
            end
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = S_FIX;
        end else begin
          hi_d  = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = S_FIX;
        end else begin
          hi_d  = div_rem;
          lo_d  = {lo_q[XLEN-2:0], div_q};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        if (!f3_q[2])     result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (f3_q[1]) result_d = neg_x(hi_q, neg_q);
        else              result_d = div0_q ? '1 : neg_x(lo_q, neg_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opa_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opa_q     <= opa_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      div0_q    <= div0_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter (XLEN=32, FAST_SPECIAL=1).
module tb_mdu_iter;

  localparam int LAT_NORM = 34;  // edges from accept edge until done is visible
  localparam int LAT_FAST = 0;   // done visible right after the accept edge

  logic        clk = 1'b0;
  logic        rst, start, ready, done, illegal;
  logic [31:0] Instruction, rs1, rs2, result;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mdu_iter #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ready       (ready),
    .Instruction (Instruction),
    .rs1         (rs1),
    .rs2         (rs2),
    .result      (result),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ei, input int el, input bit poke);
    exp_t e;
    int   edges;
    int   extra;
    e.tag = tag; e.res = er; e.ill = ei; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    Instruction = mk(f7, f3); rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after accept; they must not affect the running op.
    Instruction = mk(7'b0000001, 3'b000); rs1 = ~a; rs2 = ~b;
    edges = 0;
    while (!done && edges < 200) begin
      @(negedge clk);
      if (poke && edges == 5) begin
        Instruction = mk(7'b0000000, 3'b000);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_done"},    {63'd0, done}, 64'd1);
    chk({e.tag, "_result"},  {32'd0, result}, {32'd0, e.res});
    chk({e.tag, "_illegal"}, {63'd0, illegal}, {63'd0, e.ill});
    chk({e.tag, "_latency"}, 64'(edges), 64'(e.lat));
    @(posedge clk); #1;
    chk({e.tag, "_pulse"}, {63'd0, done}, 64'd0);
    chk({e.tag, "_hold"},  {32'd0, result}, {32'd0, e.res});
    if (poke) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({e.tag, "_single_done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int extra;
    rst = 1'b1; start = 1'b0; Instruction = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   {63'd0, ready},   64'd1);
    chk("rst_done",    {63'd0, done},    64'd0);
    chk("rst_result",  {32'd0, result},  64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul_neg",   7'b0000001, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, LAT_NORM, 1'b1);
    run_op("mulh_min",  7'b0000001, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, LAT_NORM, 1'b0);
    run_op("mulhu_max", 7'b0000001, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_NORM, 1'b0);
    run_op("mulhsu",    7'b0000001, 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, LAT_NORM, 1'b0);
    run_op("div_zero",  7'b0000001, 3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, LAT_FAST, 1'b0);
    run_op("remu_zero", 7'b0000001, 3'b111, 32'd7,        32'd0,        32'd7,        1'b0, LAT_FAST, 1'b0);
    run_op("div_ovf",   7'b0000001, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, LAT_FAST, 1'b0);
    run_op("rem_ovf",   7'b0000001, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, LAT_FAST, 1'b0);
    run_op("div_neg",   7'b0000001, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, LAT_NORM, 1'b0);
    run_op("rem_neg",   7'b0000001, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, LAT_NORM, 1'b0);
    run_op("remu",      7'b0000001, 3'b111, 32'd100,      32'd7,        32'd2,        1'b0, LAT_NORM, 1'b0);
    run_op("illegal",   7'b0000000, 3'b000, 32'd9,        32'd9,        32'd0,        1'b1, LAT_FAST, 1'b0);
    run_op("divu",      7'b0000001, 3'b101, 32'd1000,     32'd3,        32'd333,      1'b0, LAT_NORM, 1'b0);

    // Abort a DIVU mid-iteration; reset also wins over a simultaneous start.
    @(negedge clk);
    Instruction = mk(7'b0000001, 3'b101); rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; Instruction = mk(7'b0000001, 3'b000); rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    chk("abort_ready",   {63'd0, ready},   64'd1);
    chk("abort_done",    {63'd0, done},    64'd0);
    chk("abort_result",  {32'd0, result},  64'd0);
    chk("abort_illegal", {63'd0, illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);

    run_op("mul_after_rst", 7'b0000001, 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, LAT_NORM, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
Parameters (name, default, meaning):
REQ-001 XLEN, 32, operand/result width; legal values 16, 32, 64.
REQ-002 FAST_SPECIAL, 1, when 1 div-by-zero and signed-overflow complete in one cycle; when 0 they take full latency.

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; accepted only when ready=1.
REQ-006 ready  out  1  high in IDLE only.
REQ-007 Instruction  in  32  R-type instruction; funct3=[14:12], funct7=[31:25], opcode=[6:0]; sampled on accept.
REQ-008 rs1, rs2  in  XLEN  operands; sampled on accept.
REQ-009 result  out  XLEN  registered result; held stable until next accept.
REQ-010 done  out  1  one-cycle pulse when result valid.
REQ-011 illegal  out  1  valid with done; request was not an M-extension op.

Function
REQ-012 Decode: legal iff opcode=0110011 and funct7=0000001; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 FSM states IDLE, MUL, DIV, FIX, DONE; IDLE->MUL/DIV on accept of legal op; MUL/DIV->FIX after XLEN iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 Illegal op or fast special case: IDLE->DONE directly; done=1 after accept edge +1.
REQ-015 Normal latency: accept at edge E0, done=1 in cycle after edge E0+XLEN+2, for exactly one cycle.
REQ-016 Multiply: radix-2 shift-add on magnitudes, 2*XLEN-bit product; FIX applies sign; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-017 Divide: restoring, one quotient bit per cycle on magnitudes; FIX negates quotient if signs differ (DIV) and remainder to dividend's sign (REM).
REQ-018 Divisor zero: DIV/DIVU result all-ones; REM/REMU result rs1.
REQ-019 Signed overflow (rs1=most-negative, rs2=-1): DIV result rs1; REM result 0.
REQ-020 Illegal request: result=0, illegal=1 with done; no other state change.
REQ-021 start while not ready: ignored, no queuing; Instruction/rs1/rs2 changes after accept have no effect.
REQ-022 start in DONE cycle ignored (ready=0); earliest back-to-back accept is the cycle after done.
REQ-023 illegal holds with result until next accept; done never asserts without a preceding accept.

Reset
REQ-024 rst=1 at edge: state=IDLE, result=0, done=0, illegal=0, ready=1 after that edge; iteration counter and operand registers cleared.
REQ-025 rst mid-operation aborts silently: no done pulse for the aborted request; rst has priority over start in the same cycle.

Structure
REQ-026 Shared package riscv_pkg holds OPCODE_OP, FUNCT7_MULDIV, the eight M funct3 codes, and the FSM state enumeration.
REQ-027 One sub-module, mdu_div_step: combinational restoring-divide step (partial remainder, divisor -> next remainder, quotient bit), XLEN-parametrised.
REQ-028 Iteration counter width is clog2(XLEN)+1; no multipliers or dividers inferred from * or / operators.

Verification (XLEN=32, FAST_SPECIAL=1)
REQ-029 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, done 34 edges after accept, illegal=0.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV 7 / 0 -> 0xFFFFFFFF and REMU 7 % 0 -> 7, each done 1 edge after accept.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 100 % 7 -> 2.
REQ-033 Illegal (funct7=0000000) -> done after 1 edge, illegal=1, result 0; start pulsed while busy -> ignored, single done.
REQ-034 rst asserted at iteration 10 of DIVU -> no done, ready=1 next cycle; a fresh MUL 3x5 then returns 15.
